// File: rtl/arbl2tlb_sched_pkg.sv
// arbl2tlb_sched_pkg: request/snack payload types and l2id tagging constants shared by the scheduler
package arbl2tlb_sched_pkg;
  localparam int L2ID_W = 6;
  localparam int L2ID_MSB = L2ID_W - 1;
  localparam logic [L2ID_W-1:0] SNACK_BCAST_L2ID = '0;
  typedef struct packed {
    logic [L2ID_W-1:0] l2id;
    logic [15:0]       addr;
  } I_l2todr_req_type;
  typedef struct packed {
    logic [L2ID_W-1:0] l2id;
    logic [15:0]       data;
  } I_drtol2_snack_type;
endpackage

// File: rtl/arbl2tlb_fifo2.sv
// arbl2tlb_fifo2: 2-entry valid/retry FIFO; in_retry comes straight from the occupancy flop
module arbl2tlb_fifo2 #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_retry,
  input  T     in_data,
  output logic out_valid,
  input  logic out_retry,
  output T     out_data
);
  T mem [2];
  logic [1:0] cnt_q;
  logic rd_q, wr_q, push, pop;
  assign in_retry = cnt_q == 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign out_data = mem[rd_q];
  assign push = in_valid && !in_retry;
  assign pop = out_valid && !out_retry;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      rd_q <= rd_q ^ pop;
      wr_q <= wr_q ^ push;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= in_data;
endmodule

// File: rtl/arbl2tlb_sched.sv
// arbl2tlb_sched: round-robin merge of two L2 TLB request channels and tag-routed snack return.
// Define ARBL2TLB_STATS_EN to add saturating grant/stall counters.
module arbl2tlb_sched import arbl2tlb_sched_pkg::*;
`ifdef ARBL2TLB_STATS_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic               clk,
  input  logic               reset,
  input  logic               l2t0todr_req_valid,
  output logic               l2t0todr_req_retry,
  input  I_l2todr_req_type   l2t0todr_req,
  input  logic               l2t1todr_req_valid,
  output logic               l2t1todr_req_retry,
  input  I_l2todr_req_type   l2t1todr_req,
  output logic               drtol2t0_snack_valid,
  input  logic               drtol2t0_snack_retry,
  output I_drtol2_snack_type drtol2t0_snack,
  output logic               drtol2t1_snack_valid,
  input  logic               drtol2t1_snack_retry,
  output I_drtol2_snack_type drtol2t1_snack,
  output logic               l2todr_req_valid,
  input  logic               l2todr_req_retry,
  output I_l2todr_req_type   l2todr_req,
  input  logic               drtol2_snack_valid,
  output logic               drtol2_snack_retry,
  input  I_drtol2_snack_type drtol2_snack
`ifdef ARBL2TLB_STATS_EN
  ,
  output logic [CNT_W-1:0]   stat_grant0,
  output logic [CNT_W-1:0]   stat_grant1,
  output logic [CNT_W-1:0]   stat_stall
`endif
);
  I_l2todr_req_type head0, head1, req_sel;
  I_drtol2_snack_type s_head, s_clr;
  logic [1:0] f_valid, f_retry;
  logic pri_q, req_free, grant, gnt_port;
  logic s_valid, s_bcast, s_tgt, free0, free1, ld0, ld1;
  arbl2tlb_fifo2 #(.T(I_l2todr_req_type)) u_req0 (
    .clk(clk), .reset(reset),
    .in_valid(l2t0todr_req_valid), .in_retry(l2t0todr_req_retry), .in_data(l2t0todr_req),
    .out_valid(f_valid[0]), .out_retry(f_retry[0]), .out_data(head0)
  );
  arbl2tlb_fifo2 #(.T(I_l2todr_req_type)) u_req1 (
    .clk(clk), .reset(reset),
    .in_valid(l2t1todr_req_valid), .in_retry(l2t1todr_req_retry), .in_data(l2t1todr_req),
    .out_valid(f_valid[1]), .out_retry(f_retry[1]), .out_data(head1)
  );
  arbl2tlb_fifo2 #(.T(I_drtol2_snack_type)) u_snack (
    .clk(clk), .reset(reset),
    .in_valid(drtol2_snack_valid), .in_retry(drtol2_snack_retry), .in_data(drtol2_snack),
    .out_valid(s_valid), .out_retry(!(ld0 || ld1)), .out_data(s_head)
  );
  assign req_free = !l2todr_req_valid || !l2todr_req_retry;
  assign grant = req_free && (f_valid != 2'b00);
  assign gnt_port = (f_valid == 2'b11) ? pri_q : f_valid[1];
  assign f_retry = {!(grant && gnt_port), !(grant && !gnt_port)};
  always_comb begin
    req_sel = gnt_port ? head1 : head0;
    req_sel.l2id[L2ID_MSB] = gnt_port;
    s_clr = s_head;
    s_clr.l2id[L2ID_MSB] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      l2todr_req_valid <= 1'b0;
      pri_q <= 1'b0;
    end else begin
      l2todr_req_valid <= grant || (l2todr_req_valid && l2todr_req_retry);
      if (grant) pri_q <= !gnt_port;
    end
  end
  always_ff @(posedge clk)
    if (grant) l2todr_req <= req_sel;
  // a broadcast waits until both TLB registers can take it in the same cycle
  assign free0 = !drtol2t0_snack_valid || !drtol2t0_snack_retry;
  assign free1 = !drtol2t1_snack_valid || !drtol2t1_snack_retry;
  assign s_bcast = s_head.l2id == SNACK_BCAST_L2ID;
  assign s_tgt = s_head.l2id[L2ID_MSB];
  assign ld0 = s_valid && (s_bcast ? free0 && free1 : !s_tgt && free0);
  assign ld1 = s_valid && (s_bcast ? free0 && free1 : s_tgt && free1);
  always_ff @(posedge clk) begin
    if (reset) begin
      drtol2t0_snack_valid <= 1'b0;
      drtol2t1_snack_valid <= 1'b0;
    end else begin
      drtol2t0_snack_valid <= ld0 || (drtol2t0_snack_valid && drtol2t0_snack_retry);
      drtol2t1_snack_valid <= ld1 || (drtol2t1_snack_valid && drtol2t1_snack_retry);
    end
  end
  always_ff @(posedge clk) begin
    if (ld0) drtol2t0_snack <= s_clr;
    if (ld1) drtol2t1_snack <= s_clr;
  end
`ifdef ARBL2TLB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_stall <= '0;
    end else begin
      if (grant && !gnt_port && !(&stat_grant0)) stat_grant0 <= stat_grant0 + CNT_W'(1);
      if (grant && gnt_port && !(&stat_grant1)) stat_grant1 <= stat_grant1 + CNT_W'(1);
      if (l2todr_req_valid && l2todr_req_retry && !(&stat_stall)) stat_stall <= stat_stall + CNT_W'(1);
    end
  end
`endif
`ifndef SYNTHESIS
  a_req0_msb: assert property (@(posedge clk) disable iff (reset)
    l2t0todr_req_valid |-> !l2t0todr_req.l2id[L2ID_MSB]);
  a_req1_msb: assert property (@(posedge clk) disable iff (reset)
    l2t1todr_req_valid |-> !l2t1todr_req.l2id[L2ID_MSB]);
  a_req0_hold: assert property (@(posedge clk) disable iff (reset)
    l2t0todr_req_valid && l2t0todr_req_retry |=> l2t0todr_req_valid && $stable(l2t0todr_req));
  a_req1_hold: assert property (@(posedge clk) disable iff (reset)
    l2t1todr_req_valid && l2t1todr_req_retry |=> l2t1todr_req_valid && $stable(l2t1todr_req));
  a_snack_hold: assert property (@(posedge clk) disable iff (reset)
    drtol2_snack_valid && drtol2_snack_retry |=> drtol2_snack_valid && $stable(drtol2_snack));
  a_req_id: assert property (@(posedge clk) disable iff (reset)
    l2todr_req_valid |-> l2todr_req.l2id != '0);
`endif
endmodule
